// File: rtl/mux_rr_arbiter_4.sv
// mux_rr_arbiter_4
// Round-robin arbiter that drives the en/sel inputs of a 4:1 enabled mux
// (mux_1_4_en_S4) so that exactly one of four requesters owns the mux at a
// time. Each grant lasts at most MAX_BURST consecutive cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   req[3:0]   request vector, req[i]=1 means requester i wants the mux
//   en         mux enable (registered)
//   sel[1:0]   index of the current owner (registered, held while idle)
//   gnt[3:0]   one-hot grant, zero when en=0 (registered)
//   burst_cnt  cycles already used by the current owner in this grant, 0-based
//
// state | meaning
// IDLE  | no owner, en=0, gnt=0, sel holds its last value
// GRANT | owner is sel, en=1, gnt=one-hot(sel)

module mux_rr_arbiter_4 #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic       en,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic [3:0] burst_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] LP_CNT_LAST = 4'(MAX_BURST - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_sel;
  logic [1:0] r_last;
  logic [3:0] r_cnt;
  logic [3:0] r_gnt;

  logic [1:0] w_sel_nxt;
  logic [1:0] w_last_nxt;
  logic [3:0] w_cnt_nxt;
  logic [3:0] w_gnt_nxt;
  logic       w_found;
  logic [1:0] w_win;
  logic       w_release;

  // Search starts at last+1 and wraps, so the previous owner is examined
  // last. On burst expiry that gives the owner lowest priority; on a dropped
  // request its req bit is already 0, so it cannot win.
  always_comb begin
    logic [1:0] idx;
    w_found = 1'b0;
    w_win   = r_last;
    idx     = r_last;
    for (int j = 1; j <= 4; j++) begin
      idx = r_last + 2'(j);
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_win   = idx;
      end
    end
  end

  assign w_release = !req[r_sel] || (r_cnt == LP_CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_sel_nxt   = w_win;
          w_last_nxt  = w_win;
          w_cnt_nxt   = 4'd0;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_cnt_nxt = 4'd0;
          if (w_found) begin
            w_state_nxt = GRANT;
            w_sel_nxt   = w_win;
            w_last_nxt  = w_win;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
    w_gnt_nxt = (w_state_nxt == GRANT) ? (4'b0001 << w_sel_nxt) : 4'b0000;
  end

  // last resets to 3 so that index 0 is first in the search order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= 2'b00;
      r_last  <= 2'b11;
      r_cnt   <= 4'd0;
      r_gnt   <= 4'b0000;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  assign en        = (r_state == GRANT);
  assign sel       = r_sel;
  assign gnt       = r_gnt;
  assign burst_cnt = r_cnt;

endmodule

// File: tb/tb_mux_rr_arbiter_4.sv
// Testbench for mux_rr_arbiter_4: three instances (MAX_BURST 4, 2, 1) share
// clk/rst/req and are compared against a behavioural model every cycle, with
// directed scenarios followed by random request traffic.

module tb_mux_rr_arbiter_4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;

  logic       en_a  [3];
  logic [1:0] sel_a [3];
  logic [3:0] gnt_a [3];
  logic [3:0] cnt_a [3];

  logic [3:0] din = 4'b1010;
  logic       mux_out;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  int mb      [3] = '{4, 2, 1};
  int m_owner [3];
  int m_cnt   [3];
  int m_last  [3];
  int m_sel   [3];

  always #5 clk = ~clk;

  mux_rr_arbiter_4 #(.MAX_BURST(4)) u_mb4 (
    .clk(clk), .rst(rst), .req(req),
    .en(en_a[0]), .sel(sel_a[0]), .gnt(gnt_a[0]), .burst_cnt(cnt_a[0])
  );

  mux_rr_arbiter_4 #(.MAX_BURST(2)) u_mb2 (
    .clk(clk), .rst(rst), .req(req),
    .en(en_a[1]), .sel(sel_a[1]), .gnt(gnt_a[1]), .burst_cnt(cnt_a[1])
  );

  mux_rr_arbiter_4 #(.MAX_BURST(1)) u_mb1 (
    .clk(clk), .rst(rst), .req(req),
    .en(en_a[2]), .sel(sel_a[2]), .gnt(gnt_a[2]), .burst_cnt(cnt_a[2])
  );

  // Behavioural stand-in for mux_1_4_en_S4 attached to the MAX_BURST=1 arbiter.
  always_comb mux_out = en_a[2] ? din[sel_a[2]] : 1'b0;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int last);
    for (int j = 1; j <= 4; j++) begin
      if (r[(last + j) % 4]) return (last + j) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_owner[i] = -1;
      m_cnt[i]   = 0;
      m_last[i]  = 3;
      m_sel[i]   = 0;
    end
  endtask

  task automatic model_update(input logic [3:0] r, input logic rs);
    int w;
    if (rs) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      if (m_owner[i] >= 0 && r[m_owner[i]] && m_cnt[i] < mb[i] - 1) begin
        m_cnt[i]++;
      end else begin
        w = pick(r, m_last[i]);
        m_cnt[i] = 0;
        m_owner[i] = w;
        if (w >= 0) begin
          m_last[i] = w;
          m_sel[i]  = w;
        end
      end
    end
  endtask

  task automatic check_models();
    logic [3:0] egnt;
    for (int i = 0; i < 3; i++) begin
      egnt = (m_owner[i] >= 0) ? 4'(1 << m_owner[i]) : 4'b0000;
      chk($sformatf("mb%0d_en", mb[i]), 4'(en_a[i]), 4'(m_owner[i] >= 0));
      chk($sformatf("mb%0d_sel", mb[i]), 4'(sel_a[i]), 4'(m_sel[i]));
      chk($sformatf("mb%0d_gnt", mb[i]), gnt_a[i], egnt);
      chk($sformatf("mb%0d_cnt", mb[i]), cnt_a[i], 4'(m_cnt[i]));
    end
  endtask

  task automatic step(input logic [3:0] r, input logic rs);
    req = r;
    rst = rs;
    @(posedge clk);
    model_update(r, rs);
    @(negedge clk);
    check_models();
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    model_reset();
    @(negedge clk);

    // Reset then idle
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(4'b0000, 1'b0);
      chk("idle_en", 4'(en_a[0]), 4'd0);
      chk("idle_sel", 4'(sel_a[0]), 4'd0);
      chk("idle_gnt", gnt_a[0], 4'b0000);
      chk("idle_cnt", cnt_a[0], 4'd0);
    end

    // Single requester with burst rollover (MAX_BURST=4)
    for (int k = 0; k < 10; k++) begin
      step(4'b0100, 1'b0);
      chk("single_en", 4'(en_a[0]), 4'd1);
      chk("single_sel", 4'(sel_a[0]), 4'd2);
      chk("single_gnt", gnt_a[0], 4'b0100);
      chk("single_cnt", cnt_a[0], 4'(k % 4));
    end

    // Full load rotation (MAX_BURST=2) and mux output (MAX_BURST=1)
    step(4'b0000, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step(4'b1111, 1'b0);
      chk("rot_sel", 4'(sel_a[1]), 4'((k / 2) % 4));
      chk("rot_gnt", gnt_a[1], 4'(1 << ((k / 2) % 4)));
      chk("mux_en", 4'(en_a[2]), 4'd1);
      chk("mux_out", 4'(mux_out), 4'(k % 2));
    end

    // Early release with handoff (MAX_BURST=4)
    step(4'b0000, 1'b1);
    step(4'b0011, 1'b0);
    chk("early_sel0", 4'(sel_a[0]), 4'd0);
    step(4'b0011, 1'b0);
    chk("early_cnt1", cnt_a[0], 4'd1);
    step(4'b0010, 1'b0);
    chk("handoff_sel", 4'(sel_a[0]), 4'd1);
    chk("handoff_cnt", cnt_a[0], 4'd0);
    chk("handoff_en", 4'(en_a[0]), 4'd1);
    step(4'b0000, 1'b0);
    chk("drop_en", 4'(en_a[0]), 4'd0);
    chk("drop_gnt", gnt_a[0], 4'b0000);

    // Wrap-around priority (MAX_BURST=4)
    step(4'b0000, 1'b1);
    step(4'b1000, 1'b0);
    chk("wrap_own3", 4'(sel_a[0]), 4'd3);
    for (int k = 1; k < 4; k++) begin
      step(4'b1001, 1'b0);
      chk("no_preempt_sel", 4'(sel_a[0]), 4'd3);
      chk("no_preempt_cnt", cnt_a[0], 4'(k));
    end
    step(4'b1001, 1'b0);
    chk("wrap_to0", 4'(sel_a[0]), 4'd0);
    step(4'b1000, 1'b0);
    chk("back_to3", 4'(sel_a[0]), 4'd3);

    // Reset mid-grant
    step(4'b0000, 1'b1);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    chk("pre_rst_sel", 4'(sel_a[0]), 4'd2);
    step(4'b1111, 1'b1);
    chk("rst_en", 4'(en_a[0]), 4'd0);
    chk("rst_gnt", gnt_a[0], 4'b0000);
    chk("rst_sel", 4'(sel_a[0]), 4'd0);
    step(4'b1111, 1'b0);
    chk("post_rst_sel", 4'(sel_a[0]), 4'd0);
    chk("post_rst_en", 4'(en_a[0]), 4'd1);

    // Random traffic with occasional reset
    for (int k = 0; k < 400; k++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 39) == 0));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
